// File: rtl/sigma_delta_adc_multi.sv
// Multi-lane sigma-delta ADC: per-lane modulator feedback + CIC decimator +
// saturating requantiser, with frames streamed one channel at a time.

module sigma_delta_adc_lane #(
    parameter int OVERSAMPLE_RATE = 64,
    parameter int CIC_STAGES      = 2,
    parameter int ADC_BITLEN      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  strobe,
    input  logic                  lvds,
    output logic                  fb,
    output logic [ADC_BITLEN-1:0] u
);
    localparam int LOG2R = $clog2(OVERSAMPLE_RATE);
    localparam int W     = CIC_STAGES * LOG2R + 1;
    localparam int SHIFT = CIC_STAGES * LOG2R - ADC_BITLEN;
    localparam logic [W-1:0] FS = {1'b0, {(W-1){1'b1}}};

    logic [CIC_STAGES-1:0][W-1:0] integ, dly;
    logic [CIC_STAGES:0][W-1:0]   comb;
    logic [W-1:0]                 comb_q, sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fb <= 1'b0;
        else     fb <= lvds;
    end

    always_comb begin
        comb    = '0;
        comb[0] = integ[CIC_STAGES-1];
        for (int i = 0; i < CIC_STAGES; i++)
            comb[i+1] = comb[i] - dly[i];
    end

    // Modular wrap in integrators/combs is intended; the comb result is exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ  <= '0;
            dly    <= '0;
            comb_q <= '0;
        end else if (!en) begin
            integ  <= '0;
            dly    <= '0;
            comb_q <= '0;
        end else begin
            integ[0] <= integ[0] + {{(W-1){1'b0}}, fb};
            for (int i = 1; i < CIC_STAGES; i++)
                integ[i] <= integ[i] + integ[i-1];
            if (strobe) begin
                for (int i = 0; i < CIC_STAGES; i++)
                    dly[i] <= comb[i];
                comb_q <= comb[CIC_STAGES];
            end
        end
    end

    // Only full-scale (R^N) sets the top bit; clamp it so it never wraps to 0.
    assign sat = comb_q[W-1] ? FS : comb_q;
    assign u   = ADC_BITLEN'(sat >> SHIFT);
endmodule

module sigma_delta_adc_multi #(
    parameter int CHANNELS        = 4,
    parameter int OVERSAMPLE_RATE = 64,
    parameter int CIC_STAGES      = 2,
    parameter int ADC_BITLEN      = 8,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_enable,
    input  logic [CHANNELS-1:0]   adc_lvds_pin,
    output logic [CHANNELS-1:0]   adc_fb_pin,
    output logic [ADC_BITLEN-1:0] out_u_data,
    output logic [ADC_BITLEN-1:0] out_s_data,
    output logic [CW-1:0]         out_chan,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);
    localparam int LOG2R = $clog2(OVERSAMPLE_RATE);
    localparam int WW    = $clog2(CIC_STAGES + 1);
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
    localparam logic [WW-1:0] WARM_N  = WW'(CIC_STAGES);

    typedef enum logic {IDLE, SEND} state_t;

    logic [LOG2R-1:0] cnt;
    logic [WW-1:0]    warm;
    logic             strobe, comb_vld, frame_ok;
    logic [CHANNELS-1:0][ADC_BITLEN-1:0] lane_u, lane_s, hold_u, hold_s;

    state_t       state, state_n;
    logic [CW-1:0] chan, chan_n;
    logic         load, ovr_set;

    assign strobe   = adc_enable && (&cnt);
    assign frame_ok = comb_vld && (warm == WARM_N);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        sigma_delta_adc_lane #(
            .OVERSAMPLE_RATE(OVERSAMPLE_RATE),
            .CIC_STAGES     (CIC_STAGES),
            .ADC_BITLEN     (ADC_BITLEN)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (adc_enable),
            .strobe(strobe),
            .lvds  (adc_lvds_pin[k]),
            .fb    (adc_fb_pin[k]),
            .u     (lane_u[k])
        );
        assign lane_s[k] = {~lane_u[k][ADC_BITLEN-1], lane_u[k][ADC_BITLEN-2:0]};
    end

    // Decimation counter, comb-valid flag and warm-up counter shared by all lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            comb_vld <= 1'b0;
            warm     <= '0;
        end else if (!adc_enable) begin
            cnt      <= '0;
            comb_vld <= 1'b0;
            warm     <= '0;
        end else begin
            cnt      <= cnt + 1'b1;
            comb_vld <= strobe;
            if (comb_vld && warm != WARM_N) warm <= warm + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        chan_n  = chan;
        load    = 1'b0;
        ovr_set = 1'b0;
        case (state)
            IDLE: if (frame_ok) begin
                load    = 1'b1;
                state_n = SEND;
                chan_n  = '0;
            end
            SEND: begin
                ovr_set = frame_ok;
                if (out_ready) begin
                    if (chan == LAST_CH) begin
                        state_n = IDLE;
                        chan_n  = '0;
                    end else begin
                        chan_n = chan + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (!adc_enable) begin
            state_n = IDLE;
            chan_n  = '0;
            load    = 1'b0;
            ovr_set = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            chan    <= '0;
            hold_u  <= '0;
            hold_s  <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            chan  <= chan_n;
            if (load) begin
                hold_u <= lane_u;
                hold_s <= lane_s;
            end
            // A new overrun in the same cycle as a clear wins.
            if (ovr_set)          overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    assign out_valid  = (state == SEND);
    assign out_chan   = chan;
    assign out_last   = out_valid && (chan == LAST_CH);
    assign out_u_data = hold_u[chan];
    assign out_s_data = hold_s[chan];
endmodule
